// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: pipeline-side request/result bundle for the multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic               div_q, neg_q, neg_r, zero_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH:0]   acc, acc_nx, sh;
  logic               sa, sb;
  logic [WIDTH-1:0]   ma, mb, quo, rem, res_hi, res_lo;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sa = ~bus.op[0] & bus.a[WIDTH-1];
    sb = ~bus.op[0] & bus.b[WIDTH-1];
    ma = sa ? -bus.a : bus.a;
    mb = sb ? -bus.b : bus.b;
    sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b_q} : '0);
    sh = {acc[2*WIDTH-1:0], 1'b0};
    trial = sh[2*WIDTH:WIDTH] - {1'b0, b_q};
    acc_nx = div_q ? (trial[WIDTH] ? sh : {trial, sh[WIDTH-1:1], 1'b1})
                   : {1'b0, sum, acc[WIDTH-1:1]};
    prod = neg_q ? -acc_nx[2*WIDTH-1:0] : acc_nx[2*WIDTH-1:0];
    quo = acc_nx[WIDTH-1:0];
    rem = acc_nx[2*WIDTH-1:WIDTH];
    res_lo = div_q ? (zero_q ? '1 : (neg_q ? -quo : quo)) : prod[WIDTH-1:0];
    res_hi = div_q ? (zero_q ? a_q : (neg_r ? -rem : rem)) : prod[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (st == IDLE) begin
        if (bus.start) begin
          div_q    <= bus.op[1];
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          zero_q   <= bus.b == '0;
          a_q      <= bus.a;
          b_q      <= bus.op[1] ? mb : ma;
          acc      <= {{(WIDTH+1){1'b0}}, bus.op[1] ? ma : mb};
          cnt      <= CNT_W'(WIDTH);
          st       <= RUN;
          bus.busy <= 1'b1;
        end else begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
        end
      end else begin
        acc <= acc_nx;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          bus.hi   <= res_hi;
          bus.lo   <= res_lo;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          st       <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit_if #(.WIDTH(8)) bus8();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  mult_div_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi, pend_lo;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'd0) return sx * sy;
    if (o == 2'd1) return ux * uy;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (o == 2'd2) return {32'(sx % sy), 32'(sx / sy)};
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    {pend_hi, pend_lo} = model(o, x, y);
    tick();
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
  endtask
  task automatic wait_done(input string tag, input int exp_busy);
    int nb = 0;
    int g = 0;
    while (!bus.done && g < 200) begin
      if (bus.busy) nb++;
      chk({tag, " hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
      tick();
      g++;
    end
    chk({tag, " done"}, {bus.done, bus.busy}, 2'b10);
    chk({tag, " busy_cycles"}, nb, exp_busy);
    exp_hi = pend_hi;
    exp_lo = pend_lo;
    chk({tag, " result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask
  task automatic op8(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] exp);
    int nb = 0;
    int g = 0;
    bus8.start = 1'b1;
    bus8.op = o;
    bus8.a = x;
    bus8.b = y;
    tick();
    bus8.start = 1'b0;
    while (!bus8.done && g < 50) begin
      if (bus8.busy) nb++;
      tick();
      g++;
    end
    chk({tag, " done"}, {bus8.done, bus8.busy}, 2'b10);
    chk({tag, " busy_cycles"}, nb, 8);
    chk({tag, " result"}, {bus8.hi, bus8.lo}, exp);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int pulses;
    {bus.start, bus.op, bus.a, bus.b, bus.hi_we, bus.lo_we, bus.wdata} = '0;
    {bus8.start, bus8.op, bus8.a, bus8.b, bus8.hi_we, bus8.lo_we, bus8.wdata} = '0;
    tick(3);
    reset = 1'b0;
    chk("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    tick();
    chk("reset_idle", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    launch(2'd1, 32'd7, 32'd6);
    wait_done("multu_7x6", 32);
    chk("multu_7x6 value", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
    tick();
    chk("done_single_pulse", bus.done, 1'b0);
    launch(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg3x5", 32);
    chk("mult_neg3x5 value", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32);
    chk("multu_max value", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg7_2", 32);
    chk("div_neg7_2 value", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(2'd3, 32'd100, 32'd7);
    wait_done("divu_100_7", 32);
    chk("divu_100_7 value", {bus.hi, bus.lo}, {32'd2, 32'd14});
    launch(2'd3, 32'h64, 32'd0);
    wait_done("divu_by0", 32);
    chk("divu_by0 value", {bus.hi, bus.lo}, {32'h64, 32'hFFFF_FFFF});
    launch(2'd2, 32'hFFFF_FF9C, 32'd0);
    wait_done("div_by0", 32);
    chk("div_by0 value", {bus.hi, bus.lo}, {32'hFFFF_FF9C, 32'hFFFF_FFFF});
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_minneg", 32);
    chk("div_minneg value", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    launch(2'd1, 32'd1234, 32'd5678);
    tick(4);
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.a = 32'd99;
    bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    wait_done("start_while_busy", 27);
    launch(2'd0, 32'hFFFF_FF00, 32'd300);
    wait_done("b2b_first", 32);
    launch(2'd2, 32'd1000, 32'hFFFF_FFFD);
    wait_done("b2b_second", 32);
    launch(2'd1, 32'd3, 32'd4);
    tick(2);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234;
    tick();
    bus.lo_we = 1'b0;
    wait_done("mtlo_busy", 29);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234;
    tick();
    bus.lo_we = 1'b0;
    exp_lo = 32'h1234;
    chk("mtlo_idle", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    tick();
    {bus.hi_we, bus.lo_we} = 2'b00;
    exp_hi = 32'hCAFE_F00D;
    exp_lo = 32'hCAFE_F00D;
    chk("mthi_mtlo_both", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    launch(2'd3, 32'd50, 32'd8);
    bus.hi_we = 1'b0;
    chk("start_beats_write", bus.hi, exp_hi);
    wait_done("start_beats_write", 32);
    launch(2'd2, 32'd12345, 32'd77);
    tick(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("midop_reset", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    pulses = 0;
    repeat (40) begin
      if (bus.done) pulses++;
      tick();
    end
    chk("midop_reset no_done", pulses, 0);
    chk("midop_reset hold", {bus.busy, bus.hi, bus.lo}, '0);
    op8("w8_mult_80x80", 2'd0, 8'h80, 8'h80, 16'h4000);
    op8("w8_div_minneg", 2'd2, 8'h80, 8'hFF, 16'h0080);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.hi_we = 1'($urandom);
        bus.lo_we = 1'($urandom);
        bus.wdata = $urandom;
        if (bus.hi_we) exp_hi = bus.wdata;
        if (bus.lo_we) exp_lo = bus.wdata;
        tick();
        {bus.hi_we, bus.lo_we} = 2'b00;
        chk("rand_write", {bus.hi, bus.lo}, {exp_hi, exp_lo});
      end else begin
        launch(2'($urandom), pick(), pick());
        wait_done("rand_op", 32);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
